// File: rtl/pico_dds_top.sv
// Dual-channel DDS generator: 32-bit phase accumulator, four waveforms, debounced mode keys.
// Define PDDS_UART_CTRL_EN to add the UART command link (FTW/mode load) and irq event reporting.
module pico_dds_top #(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          BAUD         = 115200,
  parameter int          DEBOUNCE_CYC = 1_000_000,
  parameter logic [31:0] FTW_RST      = 32'h0001_4F8B
) (
  input  logic        sys_clk0,
  input  logic        rst_n1,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        irq_5,
  input  logic        irq_6,
  input  logic        irq_7,
  input  logic        key0_in,
  input  logic        key1_in,
  input  logic        key2_in,
  output logic [13:0] DataA,
  output logic        CLKA,
  output logic        WRTA,
  output logic [13:0] DataB,
  output logic        CLKB,
  output logic        WRTB
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  function automatic logic [13:0] wave(input logic [13:0] p, input logic [1:0] m);
    logic [25:0] prod;
    logic [13:0] y;
    prod = {13'd0, p[12:0]} * {13'd0, 13'd8191 - p[12:0]};
    y    = 14'(prod >> 11);
    case (m)
      2'd0:    wave = p[13] ? 14'h2000 - y : 14'h2000 + y;
      2'd1:    wave = p[13] ? 14'h0000 : 14'h3FFF;
      2'd2:    wave = p[13] ? ~{p[12:0], 1'b0} : {p[12:0], 1'b0};
      default: wave = p;
    endcase
  endfunction

  logic [31:0]     acc_q, acc_d, ftw_q, ftw_d;
  logic [1:0]      mode_q, mode_d;
  logic [13:0]     data_a_q, data_a_d, data_b_q, data_b_d;
  logic [2:0]      key_s1_q, key_s2_q, key_lvl_q, key_lvl_d, key_fall;
  logic [DB_W-1:0] key_cnt_q [3];
  logic [DB_W-1:0] key_cnt_d [3];
  logic            cmd_ftw_vld, cmd_mode_vld;
  logic [31:0]     cmd_ftw;
  logic [1:0]      cmd_mode;

  // A key level is accepted only after DEBOUNCE_CYC consecutive samples differ from it.
  always_comb begin
    key_lvl_d = key_lvl_q;
    for (int i = 0; i < 3; i++) begin
      key_cnt_d[i] = '0;
      if (key_s2_q[i] != key_lvl_q[i]) begin
        if (key_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) key_lvl_d[i] = key_s2_q[i];
        else key_cnt_d[i] = key_cnt_q[i] + 1'b1;
      end
    end
    key_fall = key_lvl_q & ~key_lvl_d;
  end

  // Keys override a UART mode write landing in the same cycle.
  always_comb begin
    mode_d = mode_q;
    ftw_d  = ftw_q;
    if (cmd_mode_vld) mode_d = cmd_mode;
    if (cmd_ftw_vld)  ftw_d  = cmd_ftw;
    if (key_fall[0])      mode_d = 2'd0;
    else if (key_fall[1]) mode_d = 2'd1;
    else if (key_fall[2]) mode_d = 2'd2;
  end

  always_comb begin
    acc_d    = acc_q + ftw_q;
    data_a_d = wave(acc_q[31:18], mode_q);
    data_b_d = wave(acc_q[31:18] + 14'h1000, mode_q);
  end

  always_ff @(posedge sys_clk0 or negedge rst_n1) begin
    if (!rst_n1) begin
      acc_q     <= '0;
      ftw_q     <= FTW_RST;
      mode_q    <= 2'd0;
      data_a_q  <= 14'h2000;
      data_b_q  <= 14'h2000;
      key_s1_q  <= '1;
      key_s2_q  <= '1;
      key_lvl_q <= '1;
      for (int i = 0; i < 3; i++) key_cnt_q[i] <= '0;
    end else begin
      acc_q     <= acc_d;
      ftw_q     <= ftw_d;
      mode_q    <= mode_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      key_s1_q  <= {key2_in, key1_in, key0_in};
      key_s2_q  <= key_s1_q;
      key_lvl_q <= key_lvl_d;
      for (int i = 0; i < 3; i++) key_cnt_q[i] <= key_cnt_d[i];
    end
  end

  assign DataA = data_a_q;
  assign DataB = data_b_q;
  assign CLKA  = ~sys_clk0;
  assign WRTA  = ~sys_clk0;
  assign CLKB  = ~sys_clk0;
  assign WRTB  = ~sys_clk0;

`ifdef PDDS_UART_CTRL_EN
  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int BC_W     = $clog2(BIT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_IDLE, P_FTW, P_MODE} p_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic [BC_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d, tx_byte;
  logic            rx_s1_q, rx_s2_q, rx_vld;
  p_state_e        p_state_q, p_state_d;
  logic [1:0]      p_cnt_q, p_cnt_d;
  logic [23:0]     p_sh_q, p_sh_d;
  logic [2:0]      irq_s1_q, irq_s2_q, irq_s3_q;
  logic [3:0]      pend_q, pend_d, pend_set, grant;
  tx_state_e       tx_state_q, tx_state_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [9:0]      tx_sh_q, tx_sh_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_vld     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == BC_W'(HALF_CYC - 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BC_W'(BIT_CYC - 1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      default: if (rx_cnt_q == BC_W'(BIT_CYC - 1)) begin
        rx_vld     = rx_s2_q;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // FTW bytes arrive big-endian; the 4th byte is merged directly into the load value.
  always_comb begin
    p_state_d    = p_state_q;
    p_cnt_d      = p_cnt_q;
    p_sh_d       = p_sh_q;
    cmd_ftw_vld  = 1'b0;
    cmd_ftw      = {p_sh_q, rx_sh_q};
    cmd_mode_vld = 1'b0;
    cmd_mode     = rx_sh_q[1:0];
    if (rx_vld) begin
      case (p_state_q)
        P_IDLE: begin
          p_cnt_d = '0;
          if (rx_sh_q == 8'h46)      p_state_d = P_FTW;
          else if (rx_sh_q == 8'h57) p_state_d = P_MODE;
        end
        P_FTW: begin
          p_sh_d  = {p_sh_q[15:0], rx_sh_q};
          p_cnt_d = p_cnt_q + 1'b1;
          if (p_cnt_q == 2'd3) begin
            cmd_ftw_vld = 1'b1;
            p_state_d   = P_IDLE;
          end
        end
        default: begin
          cmd_mode_vld = 1'b1;
          p_state_d    = P_IDLE;
        end
      endcase
    end
  end

  // pend bits are {ACK, P7, P6, P5}; lower index wins the transmitter.
  always_comb begin
    pend_set = {cmd_ftw_vld | cmd_mode_vld, irq_s3_q & ~irq_s2_q};
    grant    = '0;
    tx_byte  = 8'h4B;
    if (tx_state_q == TX_IDLE) begin
      if (pend_q[0])      begin grant = 4'b0001; tx_byte = 8'h05; end
      else if (pend_q[1]) begin grant = 4'b0010; tx_byte = 8'h06; end
      else if (pend_q[2]) begin grant = 4'b0100; tx_byte = 8'h07; end
      else if (pend_q[3]) begin grant = 4'b1000; tx_byte = 8'h4B; end
    end
    pend_d     = (pend_q & ~grant) | pend_set;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    if (|grant) begin
      tx_state_d = TX_SEND;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_sh_d    = {1'b1, tx_byte, 1'b0};
    end else if (tx_state_q == TX_IDLE) begin
      tx_cnt_d = '0;
    end else if (tx_cnt_q == BC_W'(BIT_CYC - 1)) begin
      tx_cnt_d = '0;
      tx_sh_d  = {1'b1, tx_sh_q[9:1]};
      tx_bit_d = tx_bit_q + 1'b1;
      if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
    end
  end

  always_ff @(posedge sys_clk0 or negedge rst_n1) begin
    if (!rst_n1) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      p_state_q  <= P_IDLE;
      p_cnt_q    <= '0;
      p_sh_q     <= '0;
      irq_s1_q   <= '1;
      irq_s2_q   <= '1;
      irq_s3_q   <= '1;
      pend_q     <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '1;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      p_state_q  <= p_state_d;
      p_cnt_q    <= p_cnt_d;
      p_sh_q     <= p_sh_d;
      irq_s1_q   <= {irq_7, irq_6, irq_5};
      irq_s2_q   <= irq_s1_q;
      irq_s3_q   <= irq_s2_q;
      pend_q     <= pend_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  assign uart_tx = tx_sh_q[0];
`else
  logic unused_ctrl;
  assign unused_ctrl  = ^{uart_rx, irq_5, irq_6, irq_7, CLK_HZ, BAUD};
  assign cmd_ftw_vld  = 1'b0;
  assign cmd_ftw      = '0;
  assign cmd_mode_vld = 1'b0;
  assign cmd_mode     = 2'd0;
  assign uart_tx      = 1'b1;
`endif
endmodule

// File: tb/tb_pico_dds_top.sv
// Directed self-checking bench for pico_dds_top; UART checks adapt to PDDS_UART_CTRL_EN.
`timescale 1ns/1ps
module tb_pico_dds_top;
  localparam int BIT = 16;
  localparam int DB  = 20;

  logic        sys_clk0 = 1'b0;
  logic        rst_n1, uart_rx, uart_tx, irq_5, irq_6, irq_7;
  logic        key0_in, key1_in, key2_in;
  logic [13:0] DataA, DataB;
  logic        CLKA, WRTA, CLKB, WRTB;

  int          tests_run;
  int          tests_failed;
  int          cyc = 0;
  logic [7:0]  tx_bytes [$];

  pico_dds_top #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .DEBOUNCE_CYC(DB), .FTW_RST(32'h0100_0000)
  ) dut (
    .sys_clk0(sys_clk0), .rst_n1(rst_n1), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .irq_5(irq_5), .irq_6(irq_6), .irq_7(irq_7),
    .key0_in(key0_in), .key1_in(key1_in), .key2_in(key2_in),
    .DataA(DataA), .CLKA(CLKA), .WRTA(WRTA),
    .DataB(DataB), .CLKB(CLKB), .WRTB(WRTB)
  );

  always #5 sys_clk0 = ~sys_clk0;

  // Count active edges since reset release; sample k reflects phase (k-1)*64.
  always @(posedge sys_clk0) if (rst_n1) cyc <= cyc + 1;

  // Decode every frame the DUT transmits into tx_bytes.
  initial begin
    wait (cyc > 0);
    forever begin
      logic [7:0] b;
      @(negedge uart_tx);
      repeat (BIT / 2) @(posedge sys_clk0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge sys_clk0);
        b[i] = uart_tx;
      end
      repeat (BIT) @(posedge sys_clk0);
      tx_bytes.push_back(b);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (BIT) @(negedge sys_clk0);
    end
  endtask

  task automatic waitIdx(input int idx);
    int k;
    k = cyc + 1;
    while (((k - 1) % 256) != idx) k++;
    while (cyc < k) @(negedge sys_clk0);
  endtask

  task automatic settle();
    repeat (DB + 10) @(negedge sys_clk0);
  endtask

  initial begin
    logic [13:0] a0, a1;
    logic [7:0]  got [4];
    tests_run = 0;
    tests_failed = 0;
    rst_n1 = 1'b1; uart_rx = 1'b1;
    irq_5 = 1'b1; irq_6 = 1'b1; irq_7 = 1'b1;
    key0_in = 1'b1; key1_in = 1'b1; key2_in = 1'b1;
    #2 rst_n1 = 1'b0;
    repeat (3) @(negedge sys_clk0);
    checkOutput("rst_dataA", DataA, 14'h2000);
    checkOutput("rst_dataB", DataB, 14'h2000);
    checkOutput("rst_uart_tx", uart_tx, 1'b1);
    checkOutput("clka_inv", {CLKA, WRTA, CLKB, WRTB}, 4'b1111);
    rst_n1 = 1'b1;

    while (cyc < 1) @(negedge sys_clk0);
    checkOutput("sine_a_p0", DataA, 14'h2000);
    checkOutput("sine_b_p0", DataB, 14'h3FFE);
    while (cyc < 2) @(negedge sys_clk0);
    checkOutput("sine_a_p64", DataA, 14'h20FD);
    checkOutput("sine_b_p64", DataB, 14'h3FFB);
    waitIdx(64);
    checkOutput("sine_a_peak", DataA, 14'h3FFE);
    waitIdx(128);
    checkOutput("sine_a_mid", DataA, 14'h2000);
    checkOutput("sine_b_trough", DataB, 14'h0002);
    waitIdx(192);
    checkOutput("sine_a_trough", DataA, 14'h0002);
    waitIdx(0);
    checkOutput("sine_a_period", DataA, 14'h2000);

    key2_in = 1'b0;
    settle();
    waitIdx(1);
    checkOutput("tri_a_p64", DataA, 14'h0080);
    waitIdx(64);
    checkOutput("tri_a_quarter", DataA, 14'h2000);
    waitIdx(127);
    checkOutput("tri_a_top", DataA, 14'h3F80);
    waitIdx(128);
    checkOutput("tri_a_fold", DataA, 14'h3FFF);
    checkOutput("tri_b_fold", DataB, 14'h1FFF);

    key0_in = 1'b0;
    repeat (10) @(negedge sys_clk0);
    key0_in = 1'b1;
    settle();
    waitIdx(1);
    checkOutput("glitch_ignored", DataA, 14'h0080);

    key1_in = 1'b0;
    settle();
    waitIdx(0);
    checkOutput("sq_a_first", DataA, 14'h3FFF);
    checkOutput("sq_b_first", DataB, 14'h3FFF);
    waitIdx(127);
    checkOutput("sq_a_half_end", DataA, 14'h3FFF);
    waitIdx(128);
    checkOutput("sq_a_second", DataA, 14'h0000);
    checkOutput("sq_b_second", DataB, 14'h0000);

    key1_in = 1'b1;
    key2_in = 1'b1;
    settle();
    waitIdx(200);
    checkOutput("release_no_change", DataA, 14'h0000);

    key0_in = 1'b0;
    key2_in = 1'b0;
    settle();
    waitIdx(64);
    checkOutput("prio_key0_peak", DataA, 14'h3FFE);
    waitIdx(1);
    checkOutput("prio_key0_p64", DataA, 14'h20FD);
    key0_in = 1'b1;
    key2_in = 1'b1;
    settle();

    applyStimulus(8'h46);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h57);
    applyStimulus(8'h03);
`ifdef PDDS_UART_CTRL_EN
    irq_5 = 1'b0;
    irq_7 = 1'b0;
    repeat (3) @(negedge sys_clk0);
    irq_5 = 1'b1;
    irq_7 = 1'b1;
    repeat (5) @(negedge sys_clk0);
    irq_5 = 1'b0;
    repeat (3) @(negedge sys_clk0);
    irq_5 = 1'b1;

    repeat (5) @(negedge sys_clk0);
    a0 = DataA;
    @(negedge sys_clk0);
    a1 = DataA;
    checkOutput("saw_step", 14'(a1 - a0), 14'd4);
    checkOutput("saw_b_lead", 14'(DataB - DataA), 14'h1000);
    repeat (4096) @(negedge sys_clk0);
    checkOutput("saw_period", DataA, a1);

    for (int t = 0; t < 2000 && tx_bytes.size() < 4; t++) @(negedge sys_clk0);
    repeat (300) @(negedge sys_clk0);
    checkOutput("tx_count", tx_bytes.size(), 4);
    for (int i = 0; i < 4; i++) got[i] = (i < tx_bytes.size()) ? tx_bytes[i] : 8'hEE;
    checkOutput("tx_ack_ftw", got[0], 8'h4B);
    checkOutput("tx_ack_mode", got[1], 8'h4B);
    checkOutput("tx_irq5", got[2], 8'h05);
    checkOutput("tx_irq7", got[3], 8'h07);

    applyStimulus(8'h57);
    applyStimulus(8'h01);
    for (int t = 0; t < 200 && uart_tx !== 1'b0; t++) @(negedge sys_clk0);
    checkOutput("tx_busy", uart_tx, 1'b0);
`else
    irq_5 = 1'b0;
    repeat (3) @(negedge sys_clk0);
    irq_5 = 1'b1;
    waitIdx(64);
    checkOutput("noctrl_ftw_fixed", DataA, 14'h3FFE);
    waitIdx(128);
    checkOutput("noctrl_mode_kept", DataA, 14'h2000);
    repeat (300) @(negedge sys_clk0);
    checkOutput("noctrl_tx_count", tx_bytes.size(), 0);
    checkOutput("noctrl_tx_idle", uart_tx, 1'b1);
    applyStimulus(8'h57);
`endif
    repeat (20) @(negedge sys_clk0);
    #2 rst_n1 = 1'b0;
    #1;
    checkOutput("midframe_rst_tx", uart_tx, 1'b1);
    checkOutput("midframe_rst_dataA", DataA, 14'h2000);
    checkOutput("midframe_rst_dataB", DataB, 14'h2000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
